// File: rtl/tone_period_meter_if.sv
// Tone period meter signal bundle: tone input and enable toward the meter,
// measurement results back from it.
interface tone_period_meter_if #(
  parameter int unsigned WIDTH = 12
);
  logic             ToneIn;
  logic             Enable;
  logic [WIDTH-1:0] HalfPeriod;
  logic             PeriodValid;
  logic             Locked;
  logic             NoTone;

  modport master (
    output ToneIn, Enable,
    input  HalfPeriod, PeriodValid, Locked, NoTone
  );

  modport slave (
    input  ToneIn, Enable,
    output HalfPeriod, PeriodValid, Locked, NoTone
  );
endinterface

// File: rtl/tone_period_meter.sv
// Tone period meter: measures the half-period of a toggling tone in Clock
// cycles, strobes each capture, and flags stable (Locked) and absent (NoTone)
// tones.
module tone_period_meter #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned MAX_COUNT = 4095,
  parameter int unsigned TOL       = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  tone_period_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   TOL_C = (WIDTH + 1)'(TOL);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync3;
  logic               w_edge;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   w_count_next;
  logic [WIDTH-1:0]   r_half_period;
  logic [WIDTH-1:0]   r_prev_period;
  logic               r_period_valid;
  logic               r_locked;
  logic               r_no_tone;
  logic               r_prev_valid;
  logic               w_capture;
  logic               w_timeout;
  logic signed [WIDTH:0] w_diff;
  logic [WIDTH:0]     w_abs_diff;

  // Both tone edges are of interest, so the edge is any change past the synchronizer.
  assign w_edge = r_sync2 ^ r_sync3;

  // Signed intermediate one bit wider than the count so the difference cannot wrap.
  assign w_diff     = $signed({1'b0, r_count}) - $signed({1'b0, r_prev_period});
  assign w_abs_diff = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);

  // Two-flop synchronizer for the asynchronous tone plus a history flop for edge detection.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= bus.ToneIn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // State and cycle counter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next state, counter update and capture/timeout decisions; Enable low overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    if (!bus.Enable) begin
      w_state_next = IDLE;
      w_count_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_count_next = '0;
          w_state_next = ARMED;
        end
        ARMED: begin
          if (w_edge) begin
            w_count_next = WIDTH'(1);
            w_state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (w_edge) begin
            w_capture    = 1'b1;
            w_count_next = WIDTH'(1);
          end else if (r_count >= MAX_C) begin
            w_timeout    = 1'b1;
            w_count_next = '0;
            w_state_next = ARMED;
          end else begin
            w_count_next = r_count + WIDTH'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_count_next = '0;
        end
      endcase
    end
  end

  // Measurement results, lock tracking and tone-absent flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_half_period  <= '0;
      r_prev_period  <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_no_tone      <= 1'b0;
      r_prev_valid   <= 1'b0;
    end else begin
      r_period_valid <= w_capture;
      if (!bus.Enable) begin
        r_locked     <= 1'b0;
        r_prev_valid <= 1'b0;
      end else if (w_timeout) begin
        r_no_tone    <= 1'b1;
        r_locked     <= 1'b0;
        r_prev_valid <= 1'b0;
      end else if (w_capture) begin
        r_half_period <= r_count;
        r_prev_period <= r_count;
        r_no_tone     <= 1'b0;
        r_prev_valid  <= 1'b1;
        // The first capture after arming has no trustworthy predecessor.
        r_locked      <= r_prev_valid && (w_abs_diff <= TOL_C);
      end
    end
  end

  assign bus.HalfPeriod  = r_half_period;
  assign bus.PeriodValid = r_period_valid;
  assign bus.Locked      = r_locked;
  assign bus.NoTone      = r_no_tone;

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
- Receive-side counterpart to the tone clock divider. It measures the half-period of an incoming square-wave tone (a divider-style toggling signal) in Clock cycles.
- Reports each measurement with a one-cycle valid strobe, flags when the tone is stable (Locked) and when the tone is absent (NoTone).
- Sits on the verification and feedback path of the player piano so note generation can be checked or calibrated against the expected divider limits.

Parameters:
- WIDTH, 12, width of the cycle counter and HalfPeriod.
- MAX_COUNT, 4095, cycles without a tone edge before timeout; must be ≤ 2^WIDTH-1 and ≥ 2.
- TOL, 2, maximum absolute difference between consecutive measurements that still counts as stable.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- ToneIn  input  1  tone square wave, asynchronous to Clock.
- Enable  input  1  measurement enable; level-sensitive.
- HalfPeriod  output  WIDTH  last captured half-period in Clock cycles.
- PeriodValid  output  1  one-cycle pulse when HalfPeriod is updated.
- Locked  output  1  last two consecutive captures are within TOL of each other.
- NoTone  output  1  timeout occurred and no capture has happened since.

Behaviour:
- Reset (asynchronous, active-high; clock is Clock):
  - All registers clear: synchronizer flops=0, Count=0, HalfPeriod=0, PrevPeriod=0, PeriodValid=0, Locked=0, NoTone=0, state=IDLE.
  - Reset asserted mid-measurement discards the partial count immediately.
- Input synchronization:
  - ToneIn passes through 2 synchronizer flops, then a third history flop.
  - Edge = sync2 XOR sync3, so both rising and falling edges count.
  - Edge is high for exactly 1 cycle, 3 Clock edges after a ToneIn change.
  - If ToneIn=1 at reset release, the resulting spurious edge only arms the block; it never produces a capture.
- State machine:
  - IDLE: Count held at 0; PeriodValid=0. Goes to ARMED when Enable=1.
  - ARMED: waits for an edge. On an edge: Count←1, go to MEASURE; no capture and no PeriodValid.
  - MEASURE, no edge: Count increments by 1 each cycle.
  - MEASURE, edge:
    - HalfPeriod←Count, PrevPeriod←HalfPeriod's new value source (Count), PeriodValid=1 for that cycle, Count←1, NoTone←0.
    - PeriodValid and the new HalfPeriod appear together on the cycle after the edge is detected.
  - MEASURE, Count reaches MAX_COUNT without an edge:
    - Timeout: NoTone←1, Locked←0, Count←0, go to ARMED.
    - HalfPeriod holds its last value.
  - Any state with Enable=0: next state IDLE, Count←0, Locked←0. HalfPeriod and NoTone hold.
- Lock rule:
  - Evaluated on every capture after the first capture following ARMED: |Count − PrevPeriod| ≤ TOL → Locked←1, otherwise Locked←0.
  - The first capture after ARMED never sets Locked, because there is no valid previous measurement.
  - The difference is computed as unsigned with a WIDTH+1 signed intermediate, so wrap-around is impossible.
- Simultaneous events:
  - An edge on the same cycle Count==MAX_COUNT counts as a capture (the edge wins); no timeout.
  - Enable=0 on the same cycle as an edge: Enable wins; no capture.
- Counter:
  - Never exceeds MAX_COUNT.
  - A half-period of N Clock cycles (ToneIn toggles every N cycles) yields HalfPeriod=N exactly, for N in 2..MAX_COUNT-1.

Test Plan:
1. Reset, Enable=1, ToneIn toggles every 1133 cycles → first edge only arms. From the 2nd edge on, PeriodValid pulses every 1133 cycles with HalfPeriod=1133. Locked=1 after the 3rd edge; NoTone=0.
2. Locked tone at 1133, then half-periods of 1135 then 1140 → Locked stays 1 after 1135 (difference 2), drops to 0 after 1140 (difference 5), and returns to 1 after a further 1140.
3. Locked tone, then ToneIn held constant → exactly 4095 cycles after the last edge, NoTone=1, Locked=0, HalfPeriod retains 1133. Toggling resumes at 500 cycles → NoTone clears on the first capture of HalfPeriod=500.
4. Edge arrives exactly when Count==MAX_COUNT (set MAX_COUNT=20, half-period 20) → capture HalfPeriod=20, PeriodValid pulses, NoTone stays 0.
5. Reset pulsed 600 cycles into a 1133 half-period → all outputs 0 immediately. The next edge only arms; a correct 1133 capture follows one half-period later.
6. Enable dropped mid-measurement for 100 cycles, then raised → no PeriodValid while low and Locked=0. After re-enable, the first edge arms and the second edge captures a correct value.
